// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared sizing helpers and read-mode enum for fifo_sync_flex
package fifo_pkg;

  typedef enum logic {
    FIFO_STD  = 1'b0,
    FIFO_FWFT = 1'b1
  } fifo_mode_e;

  localparam int FIFO_DEFAULT_DEPTH = 16;
  localparam int FIFO_DEFAULT_WIDTH = 32;

  // Address width never collapses to zero, so a 1-entry array still has a 1-bit index.
  function automatic int clog2_min1(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int ptr_width(input int depth);
    return clog2_min1(depth) + 1;
  endfunction

  function automatic int level_width(input int depth);
    return clog2_min1(depth) + 1;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem_sp2.sv
// rtl/fifo_mem_sp2.sv - register array with one write port and one asynchronous read port
module fifo_mem_sp2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DEFAULT_WIDTH,
  parameter int FIFO_DEPTH = FIFO_DEFAULT_DEPTH
) (
  input  logic                                 clk,
  input  logic                                 we,
  input  logic [clog2_min1(FIFO_DEPTH)-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]                wdata,
  input  logic [clog2_min1(FIFO_DEPTH)-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]                rdata
);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flex.sv
// rtl/fifo_sync_flex.sv - single-clock FIFO, STD/FWFT read, thresholds, level; FIFO_SYNC_FLEX_ERR_FLAGS_EN adds sticky error flags
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [DATA_WIDTH-1:0]       data_in,
  input  logic                        rd_en,
`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
  input  logic                        err_clr,
  output logic                        overflow,
  output logic                        underflow,
`endif
  output logic [DATA_WIDTH-1:0]       data_out,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int AW = clog2_min1(FIFO_DEPTH);
  localparam int PW = ptr_width(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam fifo_mode_e MODE = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;
  localparam logic [LW-1:0] AF_T = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AE_T = LW'(AEMPTY_THRESH);

  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("fifo_sync_flex: FIFO_DEPTH must be a power of two and at least 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > FIFO_DEPTH) begin : g_bad_afull
    $error("fifo_sync_flex: AFULL_THRESH out of range 1..FIFO_DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > FIFO_DEPTH - 1) begin : g_bad_aempty
    $error("fifo_sync_flex: AEMPTY_THRESH out of range 0..FIFO_DEPTH-1");
  end

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [LW-1:0]         level_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_ok;
  logic                  rd_ok;

  // Extra MSB distinguishes a full ring from an empty one when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign wr_ok = wr_en & ~full;
  assign rd_ok = rd_en & ~empty;

  assign level        = level_q;
  assign almost_full  = (level_q >= AF_T);
  assign almost_empty = (level_q <= AE_T);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      level_q <= level_q + LW'(wr_ok) - LW'(rd_ok);
    end
  end

  fifo_mem_sp2 #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (data_in),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_data)
  );

  if (MODE == FIFO_STD) begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;

    always_ff @(posedge clk) begin
      if (rst)        dout_q <= '0;
      else if (rd_ok) dout_q <= rd_data;
    end

    assign data_out = dout_q;
  end else begin : g_fwft
    // Head word is shown as soon as it exists; rd_en only acknowledges it.
    assign data_out = empty ? '0 : rd_data;
  end

`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
  // A fresh error wins over err_clr in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (err_clr)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (err_clr)   underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_sync_flex.sv
// tb/tb_fifo_sync_flex.sv - table-driven and sequence checks for fifo_sync_flex in STD and FWFT modes
module tb_fifo_sync_flex;

  typedef struct {
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic [7:0] dout;
    logic [3:0] lvl;
    logic       full;
    logic       empty;
    logic       af;
    logic       ae;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] dout_s, dout_f;
  logic       full_s, empty_s, af_s, ae_s;
  logic       full_f, empty_f, af_f, ae_f;
  logic [3:0] lvl_s, lvl_f;
`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
  logic       ovf_s, unf_s, ovf_f, unf_f;
`endif

  int n_checks = 0;
  int n_err    = 0;
  vec_t tbl[$];

  fifo_sync_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(0), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(ovf_s), .underflow(unf_s),
`endif
    .data_out(dout_s), .full(full_s), .empty(empty_s),
    .almost_full(af_s), .almost_empty(ae_s), .level(lvl_s)
  );

  fifo_sync_flex #(.DATA_WIDTH(8), .FIFO_DEPTH(8), .FWFT(1), .AFULL_THRESH(6), .AEMPTY_THRESH(2)) u_dut_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
    .err_clr(err_clr), .overflow(ovf_f), .underflow(unf_f),
`endif
    .data_out(dout_f), .full(full_f), .empty(empty_f),
    .almost_full(af_f), .almost_empty(ae_f), .level(lvl_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic vec_t mk(logic w, logic [7:0] d, logic r, logic [7:0] q, int l, logic f, logic e);
    vec_t v;
    v.wr = w; v.din = d; v.rd = r; v.dout = q; v.lvl = 4'(l);
    v.full = f; v.empty = e; v.af = (l >= 6); v.ae = (l <= 2);
    return v;
  endfunction

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = 8'h00; err_clr = 1'b0;

    // Fill/overfill then drain, then a wrapping 5/5/8/8 pass.
    for (int k = 1; k <= 8; k++) tbl.push_back(mk(1'b1, 8'(k), 1'b0, 8'h00, k, k == 8, 1'b0));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 8, 1'b1, 1'b0));
    for (int i = 1; i <= 8; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, 8'(i), 8 - i, 1'b0, i == 8));
    for (int k = 0; k < 5; k++) tbl.push_back(mk(1'b1, 8'(8'h10 + k), 1'b0, 8'h08, k + 1, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, 8'(8'h10 + i), 4 - i, 1'b0, i == 4));
    for (int k = 0; k < 8; k++) tbl.push_back(mk(1'b1, 8'(8'h20 + k), 1'b0, 8'h14, k + 1, k == 7, 1'b0));
    for (int i = 0; i < 8; i++) tbl.push_back(mk(1'b0, 8'h00, 1'b1, 8'(8'h20 + i), 7 - i, 1'b0, i == 7));

    repeat (2) @(posedge clk);
    #1;
    check("rst level", 32'(lvl_s), 0);
    check("rst empty", 32'(empty_s), 1);
    check("rst full", 32'(full_s), 0);
    check("rst almost_empty", 32'(ae_s), 1);
    check("rst almost_full", 32'(af_s), 0);
    check("rst data_out", 32'(dout_s), 0);
    check("rst fwft data_out", 32'(dout_f), 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].wr, tbl[i].din, tbl[i].rd);
      check($sformatf("vec%0d data_out", i), 32'(dout_s), 32'(tbl[i].dout));
      check($sformatf("vec%0d level", i), 32'(lvl_s), 32'(tbl[i].lvl));
      check($sformatf("vec%0d full", i), 32'(full_s), 32'(tbl[i].full));
      check($sformatf("vec%0d empty", i), 32'(empty_s), 32'(tbl[i].empty));
      check($sformatf("vec%0d almost_full", i), 32'(af_s), 32'(tbl[i].af));
      check($sformatf("vec%0d almost_empty", i), 32'(ae_s), 32'(tbl[i].ae));
    end

    // Simultaneous read+write at level 4, at full, at empty.
    for (int k = 0; k < 4; k++) cyc(1'b1, 8'(8'h30 + k), 1'b0);
    cyc(1'b1, 8'h34, 1'b1);
    check("rw mid level", 32'(lvl_s), 4);
    check("rw mid data", 32'(dout_s), 32'h30);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check($sformatf("rw mid order%0d", i), 32'(dout_s), 32'(8'h30 + i));
    end
    check("rw mid drained", 32'(empty_s), 1);
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(8'h40 + k), 1'b0);
    check("rw full pre", 32'(full_s), 1);
    cyc(1'b1, 8'h99, 1'b1);
    check("rw full level", 32'(lvl_s), 7);
    check("rw full data", 32'(dout_s), 32'h40);
    check("rw full flag", 32'(full_s), 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      check($sformatf("rw full order%0d", i), 32'(dout_s), 32'(8'h40 + i));
    end
    check("rw full drop empty", 32'(empty_s), 1);
    cyc(1'b1, 8'h55, 1'b1);
    check("rw empty level", 32'(lvl_s), 1);
    check("rw empty data held", 32'(dout_s), 32'h47);
    cyc(1'b0, 8'h00, 1'b1);
    check("rw empty read", 32'(dout_s), 32'h55);
    check("rw empty level0", 32'(lvl_s), 0);

    // FWFT head presentation.
    do_reset();
    check("fwft idle empty", 32'(empty_f), 1);
    check("fwft idle data", 32'(dout_f), 0);
    cyc(1'b1, 8'hA5, 1'b0);
    check("fwft show empty", 32'(empty_f), 0);
    check("fwft show data", 32'(dout_f), 32'hA5);
    cyc(1'b0, 8'h00, 1'b0);
    check("fwft hold data", 32'(dout_f), 32'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    check("fwft pop empty", 32'(empty_f), 1);
    check("fwft pop data", 32'(dout_f), 0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    check("fwft head1", 32'(dout_f), 32'h11);
    cyc(1'b0, 8'h00, 1'b1);
    check("fwft head2", 32'(dout_f), 32'h22);
    check("fwft level", 32'(lvl_f), 1);
    cyc(1'b0, 8'h00, 1'b1);
    check("fwft std trail", 32'(dout_s), 32'h22);

    // Reset with 5 words stored.
    for (int k = 0; k < 5; k++) cyc(1'b1, 8'(8'h60 + k), 1'b0);
    check("mid level5", 32'(lvl_s), 5);
    do_reset();
    check("mid rst level", 32'(lvl_s), 0);
    check("mid rst empty", 32'(empty_s), 1);
    check("mid rst almost_empty", 32'(ae_s), 1);
    check("mid rst almost_full", 32'(af_s), 0);
    check("mid rst data_out", 32'(dout_s), 0);
    check("mid rst fwft data", 32'(dout_f), 0);
    cyc(1'b1, 8'h3C, 1'b0);
    check("mid fwft head", 32'(dout_f), 32'h3C);
    cyc(1'b0, 8'h00, 1'b1);
    check("mid post data", 32'(dout_s), 32'h3C);
    check("mid post level", 32'(lvl_s), 0);

`ifdef FIFO_SYNC_FLEX_ERR_FLAGS_EN
    do_reset();
    check("err rst ovf", 32'(ovf_s), 0);
    check("err rst unf", 32'(unf_s), 0);
    for (int k = 0; k < 8; k++) cyc(1'b1, 8'(k), 1'b0);
    check("err no ovf yet", 32'(ovf_s), 0);
    cyc(1'b1, 8'hEE, 1'b0);
    check("err ovf set", 32'(ovf_s), 1);
    check("err ovf set fwft", 32'(ovf_f), 1);
    cyc(1'b0, 8'h00, 1'b0);
    check("err ovf sticky", 32'(ovf_s), 1);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    check("err ovf clr", 32'(ovf_s), 0);
    cyc(1'b1, 8'hEE, 1'b0);
    check("err ovf clr+new", 32'(ovf_s), 1);
    err_clr = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1);
    check("err no unf yet", 32'(unf_s), 0);
    cyc(1'b0, 8'h00, 1'b1);
    check("err unf set", 32'(unf_s), 1);
    check("err unf set fwft", 32'(unf_f), 1);
    err_clr = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    err_clr = 1'b0;
    check("err clr ovf", 32'(ovf_s), 0);
    check("err clr unf", 32'(unf_s), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_flex.md
Name: fifo_sync_flex

Overview:
- Parametrised single-clock FIFO; successor to the basic synchronous FIFO.
- Adds:
  - a selectable read mode: standard 1-cycle latency, or first-word-fall-through (FWFT);
  - programmable almost-full and almost-empty thresholds;
  - an occupancy count.
- Used as the generic buffering primitive between streaming datapath stages in one clock domain.

Parameters:
- DATA_WIDTH, 32, width of each stored word.
- FIFO_DEPTH, 16, number of entries. Must be a power of two and ≥2; any other value is a synthesis-time error.
- FWFT, 0, 0 = standard read (data 1 cycle after rd_en); 1 = first-word-fall-through.
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserted when level ≥ AFULL_THRESH. Legal range 1..FIFO_DEPTH.
- AEMPTY_THRESH, 2, almost_empty asserted when level ≤ AEMPTY_THRESH. Legal range 0..FIFO_DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- data_in  in  DATA_WIDTH  write data.
- rd_en  in  1  read/pop request.
- data_out  out  DATA_WIDTH  read data.
- full  out  1  level == FIFO_DEPTH.
- empty  out  1  level == 0 (no valid head in FWFT mode).
- almost_full  out  1  level ≥ AFULL_THRESH.
- almost_empty  out  1  level ≤ AEMPTY_THRESH.
- level  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, level = 0;
  - empty = 1, full = 0, almost_empty = 1;
  - almost_full = 0, unless AFULL_THRESH == 0 (not legal);
  - data_out = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all contents. The first write after reset is the next word read.
- Pointers: $clog2(FIFO_DEPTH)+1 bits; the MSB is the wrap bit.
  - Index = pointer LSBs; both pointers wrap modulo 2*FIFO_DEPTH.
  - full when the index bits are equal and the wrap bits differ; empty when the pointers are equal.
- Write acceptance: wr_ok = wr_en & ~full.
  - On wr_ok: mem[wr_ptr] <= data_in; wr_ptr increments.
  - A write while full is dropped silently; pointers and memory are unchanged.
- Read acceptance: rd_ok = rd_en & ~empty.
  - A read while empty is ignored.
- Simultaneous wr_en & rd_en:
  - Each is evaluated against the flags as they stand before the edge.
  - When full: only the read occurs. When empty: only the write occurs.
  - Otherwise both occur and level is unchanged.
- level update: level + wr_ok − rd_ok, registered.
  - All flags are derived from the registered level/pointers, so flags update the cycle after the edge.
- FWFT=0 (standard mode):
  - On rd_ok: data_out <= mem[rd_ptr] and rd_ptr increments; data is valid the cycle after rd_en.
  - data_out holds its last value when there is no rd_ok.
- FWFT=1:
  - data_out = mem[rd_ptr] combinationally whenever ~empty; it is 0 when empty.
  - rd_en acts as a pop/acknowledge for the displayed word.
  - A word written into an empty FIFO appears on data_out the cycle after the write edge, with empty deasserting in that same cycle.
- Write-to-read of the same entry cannot collide: a full FIFO blocks writes, and an empty FIFO blocks reads.

Optional Feature:
- Macro FIFO_SYNC_FLEX_ERR_FLAGS_EN.
- When defined, adds three ports:
  - overflow  out  1: sticky; set by wr_en & full.
  - underflow  out  1: sticky; set by rd_en & empty.
  - err_clr  in  1: clears both flags synchronously. If err_clr and a new error occur in the same cycle, the flag stays set.
  - rst clears both flags to 0.
- When undefined, these ports and their logic are absent; dropped accesses remain silent.

Decomposition:
- Package fifo_pkg:
  - function clog2_min1 (returns ≥1);
  - localparam helpers for pointer width and level width;
  - typedef enum fifo_mode_e {FIFO_STD, FIFO_FWFT}. The FWFT parameter maps onto this enum.
- Sub-module fifo_mem_sp2:
  - simple dual-port register array: 1 write port, 1 asynchronous-read port;
  - parameters DATA_WIDTH and FIFO_DEPTH.
  - Pointer, flag and mode logic stay in the top module.

Test Plan:
All scenarios use DATA_WIDTH=8, FIFO_DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2, unless stated otherwise.
1. Fill, then overfill, in STD mode:
   - Stimulus: write 0x01..0x08, then a 9th write of 0xFF.
   - Response: full=1 after the 8th write; level=8; almost_full=1 from level 6. The 0xFF is dropped.
   - Then 8 reads → data_out 0x01..0x08, each 1 cycle after its rd_en; empty=1 after the last read.
2. Wrap-around:
   - Stimulus: write 5, read 5, write 8, read 8.
   - Response: data order preserved; level returns to 0; pointers wrapped; no spurious full/empty.
3. Simultaneous read and write:
   - At level=4: level stays 4 and order is kept.
   - At full: level goes to 7 and the write is dropped.
   - At empty: level goes to 1 and no read occurs.
4. FWFT=1:
   - Stimulus: write 0xA5 to an empty FIFO.
   - Response: the next cycle has empty=0 and data_out=0xA5 with no rd_en. rd_en → empty=1.
5. Reset mid-stream:
   - Stimulus: at level=5, assert rst for 1 cycle.
   - Response: level=0, empty=1, almost_empty=1, data_out=0. A subsequent write of 0x3C, then a read, returns 0x3C.
6. With FIFO_SYNC_FLEX_ERR_FLAGS_EN defined:
   - Write when full → overflow=1 and it stays set. Read when empty → underflow=1.
   - err_clr → both flags 0.
   - err_clr together with a new overflow → overflow stays 1.
